// File: rtl/riscv_memory_stage_if.sv
// Data-memory bus between the M stage (master) and the data memory (slave).
interface riscv_memory_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/riscv_memory_stage.sv
// RV32I memory stage: E/M register, load/store sequencing over the dmem bus,
// byte-lane placement and load extension, M/W register and stall generation.
module riscv_memory_stage (
    input  logic        i_clk,
    input  logic        i_rstn,

    input  logic        i_RegWriteE,
    input  logic [1:0]  i_ResultSrcE,
    input  logic        i_MemWriteE,
    input  logic [2:0]  i_Funct3E,
    input  logic [31:0] i_ALUResultE,
    input  logic [31:0] i_WriteDataE,
    input  logic [4:0]  i_RdE,
    input  logic [31:0] i_PCPlus4E,

    output logic        o_RegWriteM,
    output logic [4:0]  o_RdM,
    output logic [31:0] o_ALUResultM,
    output logic        o_stallM,
    output logic        o_misalignM,

    riscv_memory_stage_if.master dmem,

    output logic        o_RegWriteW,
    output logic [1:0]  o_ResultSrcW,
    output logic [4:0]  o_RdW,
    output logic [31:0] o_ALUResultW,
    output logic [31:0] o_ReadDataW,
    output logic [31:0] o_PCPlus4W
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } memState_t;

    memState_t state;

    logic            regWriteM;
    logic [1:0]      resultSrcM;
    logic            memWriteM;
    logic [2:0]      funct3M;
    logic [XLEN-1:0] aluResultM;
    logic [XLEN-1:0] writeDataM;
    logic [4:0]      rdM;
    logic [XLEN-1:0] pcPlus4M;

    logic            isLoad;
    logic            isStore;
    logic            memOp;
    logic            misalign;
    logic            dmemReq;
    logic            stall;
    logic [3:0]      byteEn;
    logic [XLEN-1:0] storeData;
    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [XLEN-1:0] loadExt;

    // Decode of the op currently held in M
    always_comb begin
        isLoad   = (resultSrcM == 2'b01);
        isStore  = memWriteM;
        memOp    = isLoad | isStore;
        misalign = 1'b0;
        if (memOp) begin
            if (funct3M[1:0] == 2'b01)
                misalign = aluResultM[0];
            else if (funct3M[1:0] == 2'b10)
                misalign = (aluResultM[1:0] != 2'b00);
        end
        dmemReq = (state == IDLE) & memOp & ~misalign;
        // A load is never complete in its acceptance cycle, so it stalls there too
        stall = 1'b0;
        if (state == IDLE)
            stall = dmemReq & (~dmem.ready | isLoad);
        else
            stall = ~dmem.rvalid;
    end

    // Byte enables and store-data lane replication by access size
    always_comb begin
        byteEn    = 4'b1111;
        storeData = writeDataM;
        case (funct3M[1:0])
            2'b00: begin
                byteEn    = 4'(4'b0001 << aluResultM[1:0]);
                storeData = {4{writeDataM[7:0]}};
            end
            2'b01: begin
                byteEn    = aluResultM[1] ? 4'b1100 : 4'b0011;
                storeData = {2{writeDataM[15:0]}};
            end
            default: begin
                byteEn    = 4'b1111;
                storeData = writeDataM;
            end
        endcase
    end

    // Select the addressed byte/halfword and extend per funct3
    always_comb begin
        loadByte = dmem.rdata[7:0];
        case (aluResultM[1:0])
            2'b00:   loadByte = dmem.rdata[7:0];
            2'b01:   loadByte = dmem.rdata[15:8];
            2'b10:   loadByte = dmem.rdata[23:16];
            default: loadByte = dmem.rdata[31:24];
        endcase
        loadHalf = aluResultM[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (funct3M)
            3'b000:  loadExt = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadExt = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadExt = {24'd0, loadByte};
            3'b101:  loadExt = {16'd0, loadHalf};
            default: loadExt = dmem.rdata;
        endcase
    end

    assign dmem.req     = dmemReq;
    assign dmem.we      = memWriteM;
    assign dmem.addr    = aluResultM;
    assign dmem.be      = byteEn;
    assign dmem.wdata   = storeData;

    assign o_stallM     = stall;
    assign o_misalignM  = misalign;
    assign o_RegWriteM  = regWriteM;
    assign o_RdM        = rdM;
    assign o_ALUResultM = aluResultM;

    // Access FSM: RESP while an accepted load awaits its data
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (dmemReq && dmem.ready && isLoad) state <= RESP;
                RESP: if (dmem.rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // E/M pipeline register, held while M is stalled
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            regWriteM  <= 1'b0;
            resultSrcM <= 2'b00;
            memWriteM  <= 1'b0;
            funct3M    <= 3'b000;
            aluResultM <= '0;
            writeDataM <= '0;
            rdM        <= 5'd0;
            pcPlus4M   <= '0;
        end else if (!stall) begin
            regWriteM  <= i_RegWriteE;
            resultSrcM <= i_ResultSrcE;
            memWriteM  <= i_MemWriteE;
            funct3M    <= i_Funct3E;
            aluResultM <= i_ALUResultE;
            writeDataM <= i_WriteDataE;
            rdM        <= i_RdE;
            pcPlus4M   <= i_PCPlus4E;
        end
    end

    // M/W pipeline register: completed op, or a bubble while stalled
    always_ff @(posedge i_clk) begin
        if (!i_rstn || stall) begin
            o_RegWriteW  <= 1'b0;
            o_ResultSrcW <= 2'b00;
            o_RdW        <= 5'd0;
            o_ALUResultW <= '0;
            o_ReadDataW  <= '0;
            o_PCPlus4W   <= '0;
        end else begin
            o_RegWriteW  <= regWriteM & ~misalign;
            o_ResultSrcW <= resultSrcM;
            o_RdW        <= rdM;
            o_ALUResultW <= aluResultM;
            o_ReadDataW  <= (state == RESP) ? loadExt : '0;
            o_PCPlus4W   <= pcPlus4M;
        end
    end

endmodule
